mem_access_unit: RTL and testbench

- Initiator-side load/store controller that drives the 256-word synchronous data memory on behalf of the execute stage.
- Accepts byte-addressed load/store requests over a valid/ready handshake and translates them to word accesses.
- Loads: extracts and sign/zero-extends bytes and halfwords.
- Sub-word stores: read-modify-write, because the memory has no byte enables.
- Returns one response per request over a valid/ready handshake.

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/mem_lane_format.sv | 70 +++++++
 rtl/mem_access_unit.sv | 140 ++++++++++++++
 tb/tb_mem_access_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store unit.
//   - size_e  : request size encoding (byte / half / word / illegal)
//   - state_e : sequencing states of mem_access_unit
//   - req_t   : fields latched from an accepted request
package mem_pkg;

  localparam int unsigned DEPTH_LOG2_DEF = 8;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

  typedef struct packed {
    logic              write;
    size_e             size;
    logic              sgn;
    logic [1:0]        lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Size/alignment legality; the address-range part is checked by the caller.
  function automatic logic size_align_err(size_e size, logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = lane[0];
      SIZE_W:  err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_format.sv
// Lane formatting for the load/store unit (purely combinational).
//   i_word    : 32-bit word read from memory
//   i_lane    : byte lane (address bits [1:0])
//   i_size    : access size
//   i_sgn     : sign-extend loads
//   i_wdata   : right-justified store data
//   o_load_c  : extracted and extended load data
//   o_merge_c : i_word with the store byte/half inserted at the lane
module mem_lane_format
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_lane,
  input  size_e             i_size,
  input  logic              i_sgn,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_load_c,
  output logic [DATA_W-1:0] o_merge_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select
  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  // Load extract and extend
  always_comb begin
    o_load_c = '0;
    case (i_size)
      SIZE_B:  o_load_c = {{24{i_sgn & w_byte[7]}}, w_byte};
      SIZE_H:  o_load_c = {{16{i_sgn & w_half[15]}}, w_half};
      SIZE_W:  o_load_c = i_word;
      default: o_load_c = '0;
    endcase
  end

  // Store merge into the previously read word
  always_comb begin
    o_merge_c = i_word;
    case (i_size)
      SIZE_B: begin
        case (i_lane)
          2'd0: o_merge_c[7:0]   = i_wdata[7:0];
          2'd1: o_merge_c[15:8]  = i_wdata[7:0];
          2'd2: o_merge_c[23:16] = i_wdata[7:0];
          2'd3: o_merge_c[31:24] = i_wdata[7:0];
          default: o_merge_c = i_word;
        endcase
      end
      SIZE_H: begin
        if (i_lane[1]) o_merge_c[31:16] = i_wdata[15:0];
        else           o_merge_c[15:0]  = i_wdata[15:0];
      end
      SIZE_W:  o_merge_c = i_wdata;
      default: o_merge_c = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller driving a single-port synchronous word memory.
// Byte-addressed requests become word accesses; sub-word stores are done
// as read-modify-write since the memory has no byte enables.
//   req_*  : request handshake (req_ready combinational from state/rst_n)
//   resp_* : response handshake, held until resp_ready
//   mem_*  : memory interface; read data arrives the cycle after the address
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned ABITS = DEPTH_LOG2 + 2;

  state_e            r_state;
  req_t              r_req;
  size_e             w_size;
  logic              w_err;
  logic              w_word_store;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merge;

  assign req_ready = (r_state == IDLE) && rst_n;

  // Request decode and rejection check at accept time
  assign w_size       = size_e'(req_size);
  assign w_err        = size_align_err(w_size, req_addr[1:0]) ||
                        ((req_addr >> ABITS) != '0);
  assign w_word_store = req_write && (w_size == SIZE_W);

  // Formatting always works on the live memory read data; it is only
  // consumed in WAIT, when that data belongs to this transaction.
  mem_lane_format u_fmt (
    .i_word    (mem_read_data),
    .i_lane    (r_req.lane),
    .i_size    (r_req.size),
    .i_sgn     (r_req.sgn),
    .i_wdata   (r_req.wdata),
    .o_load_c  (w_load),
    .o_merge_c (w_merge)
  );

  // Sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_req            <= '0;
      resp_valid       <= 1'b0;
      resp_err         <= 1'b0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req.write <= req_write;
            r_req.size  <= w_size;
            r_req.sgn   <= req_signed;
            r_req.lane  <= req_addr[1:0];
            r_req.wdata <= req_wdata;
            if (w_err) begin
              // Rejected: no memory access at all
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              resp_valid <= 1'b1;
              r_state    <= RESP;
            end else begin
              mem_address <= ADDR_W'(req_addr[ABITS-1:2]);
              if (w_word_store) begin
                mem_write_enable <= 1'b1;
                mem_write_data   <= req_wdata;
              end else begin
                mem_write_enable <= 1'b0;
              end
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (r_req.write && (r_req.size == SIZE_W)) begin
            mem_write_enable <= 1'b0;
            resp_err         <= 1'b0;
            resp_rdata       <= '0;
            resp_valid       <= 1'b1;
            r_state          <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_req.write) begin
            mem_write_data   <= w_merge;
            mem_write_enable <= 1'b1;
            r_state          <= WRITE;
          end else begin
            resp_rdata <= w_load;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            r_state    <= RESP;
          end
        end
        WRITE: begin
          mem_write_enable <= 1'b0;
          resp_err         <= 1'b0;
          resp_rdata       <= '0;
          resp_valid       <= 1'b1;
          r_state          <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural 256-word memory.
module tb_mem_access_unit;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256] = '{default: 32'h0};

  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // Synchronous memory: registered read, old data on same-cycle write
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_address[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Monitor: responses and memory writes against the scoreboard queues
  always @(negedge clk) begin : monitor
    resp_t er;
    wr_t   ew;
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected got rdata=%h err=%b", resp_rdata, resp_err);
      end else begin
        er = exp_resp.pop_front();
        chk("resp_rdata", resp_rdata, er.rdata);
        chk("resp_err", 32'(resp_err), 32'(er.err));
      end
    end
    if (mem_write_enable) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_unexpected got addr=%h data=%h", mem_address, mem_write_data);
      end else begin
        ew = exp_wr.pop_front();
        chk("mem_wr_addr", mem_address, ew.addr);
        chk("mem_wr_data", mem_write_data, ew.data);
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  // One full transaction; called at posedge+1 with the unit idle
  task automatic do_req(input string nm, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee,
                        input int lat_exp, input int hold);
    resp_t r;
    int    lat;
    r.rdata = er;
    r.err   = ee;
    exp_resp.push_back(r);
    resp_ready = (hold == 0);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(lat_exp));
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, resp_rdata, er);
      chk({nm, "_hold_err"}, 32'(resp_err), 32'(ee));
      chk({nm, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_post_valid"}, 32'(resp_valid), 32'd0);
    chk({nm, "_post_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    chk("rst_req_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready_high", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Word stores / loads
    push_wr(32'd4, 32'hDEADBEEF);
    do_req("sw10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0);
    do_req("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0);
    push_wr(32'd1, 32'h11223344);
    do_req("sw04", 1, 2'b10, 0, 32'h04, 32'h11223344, 32'h0, 0, 2, 0);
    push_wr(32'd3, 32'hCAFEF00D);
    do_req("sw0c", 1, 2'b10, 0, 32'h0C, 32'hCAFEF00D, 32'h0, 0, 2, 0);

    // Byte RMW and byte loads
    push_wr(32'd1, 32'h11AA3344);
    do_req("sb06", 1, 2'b00, 0, 32'h06, 32'h777777AA, 32'h0, 0, 4, 0);
    do_req("lbs06", 0, 2'b00, 1, 32'h06, 32'h0, 32'hFFFFFFAA, 0, 3, 0);
    do_req("lbu06", 0, 2'b00, 0, 32'h06, 32'h0, 32'h000000AA, 0, 3, 0);
    do_req("lbu04", 0, 2'b00, 0, 32'h04, 32'h0, 32'h00000044, 0, 3, 0);
    do_req("lbs07", 0, 2'b00, 1, 32'h07, 32'h0, 32'h00000011, 0, 3, 0);

    // Halfword RMW and loads
    push_wr(32'd2, 32'h80010000);
    do_req("sh0a", 1, 2'b01, 0, 32'h0A, 32'h12348001, 32'h0, 0, 4, 0);
    do_req("lhs0a", 0, 2'b01, 1, 32'h0A, 32'h0, 32'hFFFF8001, 0, 3, 0);
    do_req("lhu0a", 0, 2'b01, 0, 32'h0A, 32'h0, 32'h00008001, 0, 3, 0);
    do_req("lhs04", 0, 2'b01, 1, 32'h04, 32'h0, 32'h00003344, 0, 3, 0);

    // Rejected requests: no write expected
    do_req("err_h03", 1, 2'b01, 0, 32'h03, 32'hFFFF, 32'h0, 1, 1, 0);
    do_req("err_w02", 1, 2'b10, 0, 32'h02, 32'h1, 32'h0, 1, 1, 0);
    do_req("err_sz3", 1, 2'b11, 0, 32'h00, 32'h1, 32'h0, 1, 1, 0);
    do_req("err_w400", 1, 2'b10, 0, 32'h400, 32'h1, 32'h0, 1, 1, 0);
    do_req("err_lh03", 0, 2'b01, 1, 32'h03, 32'h0, 32'h0, 1, 1, 0);

    // Backpressure, then back-to-back accept
    do_req("bp_lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 5);
    do_req("lbs11", 0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFBE, 0, 3, 0);

    // Reset while a byte store sits in WAIT: no write, no response
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0D;
    req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_resp_err", 32'(resp_err), 32'd0);
    chk("rw_resp_rdata", resp_rdata, 32'd0);
    chk("rw_mem_we", 32'(mem_write_enable), 32'd0);
    chk("rw_mem_addr", mem_address, 32'd0);
    chk("rw_mem_wdata", mem_write_data, 32'd0);
    chk("rw_req_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rw_req_ready_high", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rw_mem3", mem[3], 32'hCAFEF00D);
    do_req("lw0c", 0, 2'b10, 0, 32'h0C, 32'h0, 32'hCAFEF00D, 0, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
    chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
